sdram_avmm_arbiter: RTL and testbench
=====================================

// Module: sdram_avmm_arbiter
// PURPOSE
//  Two-requester Avalon-MM arbiter in front of the single SDRAM controller slave (16-bit, 64 MB).
//  Lets the HPS bridge (r0) and an FPGA master (r1) share the controller through one registered command stage.
//  Pipelined reads are routed back to their issuer by an in-order tag FIFO.
// PARAMETERS
//  ADDR_W    25  word address width (13 row + 10 col + 2 bank)
//  DATA_W    16  data width; BE_W = DATA_W/8
//  MAX_PEND   8  max outstanding reads; tag FIFO depth, power of 2
// PORTS
//  clk_clk            in   1        single clock
//  reset_reset_n      in   1        async assert, active-low reset
//  rN_address         in   ADDR_W   requester N (N=0,1) word address
//  rN_read/rN_write   in   1        requester N command strobes, mutually exclusive
//  rN_writedata       in   DATA_W   requester N write data
//  rN_byteenable      in   BE_W     requester N byte enables
//  rN_waitrequest     out  1        low = command accepted this cycle
//  rN_readdata        out  DATA_W   requester N read data
//  rN_readdatavalid   out  1        requester N read data valid
//  m_address/m_read/m_write/m_writedata/m_byteenable  out  as above  to controller
//  m_waitrequest      in   1        controller stall
//  m_readdata         in   DATA_W   controller read data
//  m_readdatavalid    in   1        controller read data valid
//  err_orphan         out  1        sticky: readdatavalid arrived with tag FIFO empty
// BEHAVIOUR
//  Reset: m_read=m_write=0, m_* data/address=0, rN_readdatavalid=0, rN_readdata=0, rN_waitrequest=1,
//   err_orphan=0, state IDLE, last_grant=r1 (so r0 wins first tie), FIFO empty.
//  FSM: IDLE (command register empty), ISSUE (command register valid, m_read|m_write=1).
//  can_take = (state==IDLE) | (state==ISSUE & !m_waitrequest).
//  Eligible rN: read|write asserted, and for reads FIFO not full after pending pushes.
//  Pick: one eligible wins; both eligible -> the one != last_grant (round robin).
//  rN_waitrequest = !(can_take & pick==N), combinational; all other cycles 1.
//  On accept: capture address/data/be/cmd and the winner ID into command reg; last_grant<=winner;
//   state->ISSUE. Request-to-m_* latency is exactly 1 cycle.
//  ISSUE: m_* held stable while m_waitrequest=1. When !m_waitrequest: a read pushes winner ID into the
//   FIFO; state->ISSUE if a new accept happens that cycle (back-to-back, 1 cmd/cycle), else IDLE.
//  Read FIFO-full gate: a read is not eligible while occupancy + (reg holds read) >= MAX_PEND;
//   writes stay eligible.
//  Return: on m_readdatavalid pop head ID; the next edge drives rN_readdata<=m_readdata and
//   rN_readdatavalid<=1 for the matching N only (1-cycle registered). Non-owner readdata holds.
//  Simultaneous push and pop in one cycle: occupancy unchanged; push at full is impossible by gating.
//  m_readdatavalid with FIFO empty: data dropped, err_orphan<=1, held until reset.
//  A requester that drops its strobe while waitrequest=1 is legal; nothing is latched.
//  Reset mid-transfer: all state cleared asynchronously; pending reads are discarded and later
//   returns count as orphans (controller must be reset together).
// STRUCTURE
//  Package sdram_arb_pkg: state enum {IDLE, ISSUE}, req_id_t (1 bit), R0/R1 constants, DEPTH_W=$clog2(MAX_PEND).
//  Sub-module sdram_arb_tag_fifo: sync FIFO, req_id_t x MAX_PEND, count output, async active-low reset.
//  Top holds the pick logic, command register, FSM and return-routing register.
// TESTING
//  1 Both request reads at addr 0x10/0x20, m_waitrequest=0 -> m_read r0 then r1 on consecutive cycles;
//    returns DATA 0xAAAA, 0x5555 go to r0, then r1.
//  2 Both hold writes continuously for 6 cycles -> grants alternate r0,r1,r0,...; 3 writes each.
//  3 m_waitrequest=1 for 4 cycles during write 0x1234/be=2'b01 -> m_* stable all 4 cycles; both rN_waitrequest=1.
//  4 r1 issues 8 reads with no returns -> 9th read stalled; an r0 write is still accepted; one return frees a slot.
//  5 m_readdatavalid pulse with FIFO empty -> no rN_readdatavalid; err_orphan=1 until reset.
//  6 Reset asserted with 3 reads pending -> all outputs reach reset values immediately; FIFO count=0.

Source files
------------

// File: rtl/sdram_arb_pkg.sv
// Shared types and constants for the two-requester SDRAM Avalon-MM arbiter.
package sdram_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } state_t;

  typedef logic req_id_t;

  localparam req_id_t R0 = 1'b0;
  localparam req_id_t R1 = 1'b1;

  localparam int MAX_PEND_DEF = 8;
  localparam int DEPTH_W      = $clog2(MAX_PEND_DEF);

endpackage

// File: rtl/sdram_arb_tag_fifo.sv
// In-order FIFO of requester IDs for outstanding reads; head names the owner of the next return.
module sdram_arb_tag_fifo
  import sdram_arb_pkg::*;
#(
  parameter int DEPTH = MAX_PEND_DEF
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_push,
  input  req_id_t                    i_din,
  input  logic                       i_pop,
  output req_id_t                    o_dout,
  output logic                       o_empty,
  output logic [$clog2(DEPTH):0]     o_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  req_id_t            r_mem [DEPTH];
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [CNT_W-1:0]   r_count;

  logic w_do_push;
  logic w_do_pop;

  assign o_empty   = (r_count == '0);
  assign w_do_pop  = i_pop & !o_empty;
  assign w_do_push = i_push & (r_count != CNT_W'(DEPTH));
  assign o_dout    = r_mem[r_rd_ptr];
  assign o_count   = r_count;

  // NOTE: storage is not reset; only pointers and count define validity, so entries may hold stale IDs.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_din;
  end

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/sdram_avmm_arbiter.sv
// Round-robin arbiter sharing one SDRAM controller slave between the HPS bridge (r0) and an FPGA master (r1).
module sdram_avmm_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int ADDR_W   = 25,
  parameter int DATA_W   = 16,
  parameter int MAX_PEND = MAX_PEND_DEF
) (
  input  logic                  clk_clk,
  input  logic                  reset_reset_n,
  input  logic [ADDR_W-1:0]     r0_address,
  input  logic                  r0_read,
  input  logic                  r0_write,
  input  logic [DATA_W-1:0]     r0_writedata,
  input  logic [DATA_W/8-1:0]   r0_byteenable,
  output logic                  r0_waitrequest,
  output logic [DATA_W-1:0]     r0_readdata,
  output logic                  r0_readdatavalid,
  input  logic [ADDR_W-1:0]     r1_address,
  input  logic                  r1_read,
  input  logic                  r1_write,
  input  logic [DATA_W-1:0]     r1_writedata,
  input  logic [DATA_W/8-1:0]   r1_byteenable,
  output logic                  r1_waitrequest,
  output logic [DATA_W-1:0]     r1_readdata,
  output logic                  r1_readdatavalid,
  output logic [ADDR_W-1:0]     m_address,
  output logic                  m_read,
  output logic                  m_write,
  output logic [DATA_W-1:0]     m_writedata,
  output logic [DATA_W/8-1:0]   m_byteenable,
  input  logic                  m_waitrequest,
  input  logic [DATA_W-1:0]     m_readdata,
  input  logic                  m_readdatavalid,
  output logic                  err_orphan
);

  localparam int BE_W  = DATA_W / 8;
  localparam int CNT_W = $clog2(MAX_PEND) + 1;
  localparam logic [CNT_W-1:0] PEND_LIMIT = CNT_W'(MAX_PEND);

  state_t              r_state;
  req_id_t             r_last_grant;
  req_id_t             r_cmd_id;
  logic [ADDR_W-1:0]   r_m_address;
  logic                r_m_read;
  logic                r_m_write;
  logic [DATA_W-1:0]   r_m_writedata;
  logic [BE_W-1:0]     r_m_byteenable;
  logic [DATA_W-1:0]   r_r0_readdata;
  logic [DATA_W-1:0]   r_r1_readdata;
  logic                r_r0_readdatavalid;
  logic                r_r1_readdatavalid;
  logic                r_err_orphan;

  logic                w_issue_done;
  logic                w_can_take;
  logic                w_reg_read;
  logic [CNT_W-1:0]    w_fifo_count;
  logic [CNT_W-1:0]    w_occ;
  logic                w_rd_block;
  logic                w_elig0;
  logic                w_elig1;
  logic                w_accept;
  req_id_t             w_pick;
  logic                w_push;
  logic                w_pop;
  logic                w_fifo_empty;
  req_id_t             w_head;

  assign w_issue_done = (r_state == ISSUE) & !m_waitrequest;
  assign w_can_take   = (r_state == IDLE) | w_issue_done;

  // A read still sitting in the command register already owns a FIFO slot.
  assign w_reg_read = (r_state == ISSUE) & r_m_read;
  assign w_occ      = w_fifo_count + CNT_W'(w_reg_read);
  assign w_rd_block = (w_occ >= PEND_LIMIT);

  assign w_elig0  = r0_write | (r0_read & !w_rd_block);
  assign w_elig1  = r1_write | (r1_read & !w_rd_block);
  assign w_pick   = (w_elig0 & w_elig1) ? ~r_last_grant : (w_elig1 ? R1 : R0);
  assign w_accept = w_can_take & (w_elig0 | w_elig1);

  assign r0_waitrequest = !(w_accept & (w_pick == R0));
  assign r1_waitrequest = !(w_accept & (w_pick == R1));

  assign w_push = w_issue_done & r_m_read;
  assign w_pop  = m_readdatavalid & !w_fifo_empty;

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      r_state        <= IDLE;
      r_last_grant   <= R1;
      r_cmd_id       <= R0;
      r_m_address    <= '0;
      r_m_read       <= 1'b0;
      r_m_write      <= 1'b0;
      r_m_writedata  <= '0;
      r_m_byteenable <= '0;
    end else begin
      case (r_state)
        IDLE:    if (w_accept) r_state <= ISSUE;
        ISSUE:   if (w_issue_done && !w_accept) r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
      if (w_accept) begin
        r_cmd_id     <= w_pick;
        r_last_grant <= w_pick;
        if (w_pick == R0) begin
          r_m_address    <= r0_address;
          r_m_read       <= r0_read;
          r_m_write      <= r0_write;
          r_m_writedata  <= r0_writedata;
          r_m_byteenable <= r0_byteenable;
        end else begin
          r_m_address    <= r1_address;
          r_m_read       <= r1_read;
          r_m_write      <= r1_write;
          r_m_writedata  <= r1_writedata;
          r_m_byteenable <= r1_byteenable;
        end
      end else if (w_issue_done) begin
        r_m_read  <= 1'b0;
        r_m_write <= 1'b0;
      end
    end
  end

  // Return path: the FIFO head names the owner; the other requester's readdata is left untouched.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      r_r0_readdata      <= '0;
      r_r1_readdata      <= '0;
      r_r0_readdatavalid <= 1'b0;
      r_r1_readdatavalid <= 1'b0;
      r_err_orphan       <= 1'b0;
    end else begin
      r_r0_readdatavalid <= w_pop & (w_head == R0);
      r_r1_readdatavalid <= w_pop & (w_head == R1);
      if (w_pop && (w_head == R0)) r_r0_readdata <= m_readdata;
      if (w_pop && (w_head == R1)) r_r1_readdata <= m_readdata;
      if (m_readdatavalid && w_fifo_empty) r_err_orphan <= 1'b1;
    end
  end

  sdram_arb_tag_fifo #(
    .DEPTH (MAX_PEND)
  ) u_fifo (
    .clk     (clk_clk),
    .rst_n   (reset_reset_n),
    .i_push  (w_push),
    .i_din   (r_cmd_id),
    .i_pop   (w_pop),
    .o_dout  (w_head),
    .o_empty (w_fifo_empty),
    .o_count (w_fifo_count)
  );

  assign m_address        = r_m_address;
  assign m_read           = r_m_read;
  assign m_write          = r_m_write;
  assign m_writedata      = r_m_writedata;
  assign m_byteenable     = r_m_byteenable;
  assign r0_readdata      = r_r0_readdata;
  assign r1_readdata      = r_r1_readdata;
  assign r0_readdatavalid = r_r0_readdatavalid;
  assign r1_readdatavalid = r_r1_readdatavalid;
  assign err_orphan       = r_err_orphan;

endmodule

// File: tb/tb_sdram_avmm_arbiter.sv
// Directed bench for sdram_avmm_arbiter: arbitration order, stalls, read-tag gating, return routing, orphans, reset.
module tb_sdram_avmm_arbiter;

  localparam int ADDR_W = 25;
  localparam int DATA_W = 16;
  localparam int BE_W   = DATA_W / 8;

  logic              clk_clk;
  logic              reset_reset_n;
  logic [ADDR_W-1:0] r0_address, r1_address;
  logic              r0_read, r0_write, r1_read, r1_write;
  logic [DATA_W-1:0] r0_writedata, r1_writedata;
  logic [BE_W-1:0]   r0_byteenable, r1_byteenable;
  logic              r0_waitrequest, r1_waitrequest;
  logic [DATA_W-1:0] r0_readdata, r1_readdata;
  logic              r0_readdatavalid, r1_readdatavalid;
  logic [ADDR_W-1:0] m_address;
  logic              m_read, m_write;
  logic [DATA_W-1:0] m_writedata;
  logic [BE_W-1:0]   m_byteenable;
  logic              m_waitrequest;
  logic [DATA_W-1:0] m_readdata;
  logic              m_readdatavalid;
  logic              err_orphan;

  int n_cmp = 0;
  int n_err = 0;
  int n0, n1;

  sdram_avmm_arbiter #(
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W),
    .MAX_PEND (8)
  ) dut (
    .clk_clk          (clk_clk),
    .reset_reset_n    (reset_reset_n),
    .r0_address       (r0_address),
    .r0_read          (r0_read),
    .r0_write         (r0_write),
    .r0_writedata     (r0_writedata),
    .r0_byteenable    (r0_byteenable),
    .r0_waitrequest   (r0_waitrequest),
    .r0_readdata      (r0_readdata),
    .r0_readdatavalid (r0_readdatavalid),
    .r1_address       (r1_address),
    .r1_read          (r1_read),
    .r1_write         (r1_write),
    .r1_writedata     (r1_writedata),
    .r1_byteenable    (r1_byteenable),
    .r1_waitrequest   (r1_waitrequest),
    .r1_readdata      (r1_readdata),
    .r1_readdatavalid (r1_readdatavalid),
    .m_address        (m_address),
    .m_read           (m_read),
    .m_write          (m_write),
    .m_writedata      (m_writedata),
    .m_byteenable     (m_byteenable),
    .m_waitrequest    (m_waitrequest),
    .m_readdata       (m_readdata),
    .m_readdatavalid  (m_readdatavalid),
    .err_orphan       (err_orphan)
  );

  initial clk_clk = 1'b0;
  always #5 clk_clk = ~clk_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; combinational outputs are sampled one unit later.
  task automatic tick();
    @(posedge clk_clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle_inputs();
    r0_address = '0; r0_read = 1'b0; r0_write = 1'b0; r0_writedata = '0; r0_byteenable = '0;
    r1_address = '0; r1_read = 1'b0; r1_write = 1'b0; r1_writedata = '0; r1_byteenable = '0;
    m_waitrequest = 1'b0; m_readdata = '0; m_readdatavalid = 1'b0;
  endtask

  initial begin
    reset_reset_n = 1'b0;
    idle_inputs();
    repeat (2) @(posedge clk_clk);
    #1 reset_reset_n = 1'b1;
    settle();

    // Reset state
    check("rst_m_read",    m_read, 0);
    check("rst_m_write",   m_write, 0);
    check("rst_m_address", m_address, 0);
    check("rst_m_wdata",   m_writedata, 0);
    check("rst_r0_wait",   r0_waitrequest, 1);
    check("rst_r1_wait",   r1_waitrequest, 1);
    check("rst_r0_rdv",    r0_readdatavalid, 0);
    check("rst_r1_rdv",    r1_readdatavalid, 0);
    check("rst_err",       err_orphan, 0);
    check("rst_count",     dut.w_fifo_count, 0);

    // 1: simultaneous reads, r0 wins the first tie, returns routed in order
    r0_address = 25'h10; r0_read = 1'b1;
    r1_address = 25'h20; r1_read = 1'b1;
    settle();
    check("t1_r0_wait", r0_waitrequest, 0);
    check("t1_r1_wait", r1_waitrequest, 1);
    tick();
    check("t1_m_read_a", m_read, 1);
    check("t1_m_addr_a", m_address, 32'h10);
    r0_read = 1'b0;
    settle();
    check("t1_r1_wait_b", r1_waitrequest, 0);
    tick();
    check("t1_m_read_b", m_read, 1);
    check("t1_m_addr_b", m_address, 32'h20);
    r1_read = 1'b0;
    tick();
    check("t1_m_read_idle", m_read, 0);
    m_readdata = 16'hAAAA; m_readdatavalid = 1'b1;
    tick();
    check("t1_r0_rdv",   r0_readdatavalid, 1);
    check("t1_r0_data",  r0_readdata, 32'hAAAA);
    check("t1_r1_rdv_a", r1_readdatavalid, 0);
    m_readdata = 16'h5555;
    tick();
    m_readdatavalid = 1'b0;
    check("t1_r1_rdv",    r1_readdatavalid, 1);
    check("t1_r1_data",   r1_readdata, 32'h5555);
    check("t1_r0_rdv_b",  r0_readdatavalid, 0);
    check("t1_r0_hold",   r0_readdata, 32'hAAAA);

    // 2: both hold writes for 6 cycles, grants alternate starting with r0
    r0_address = 25'h100; r0_writedata = 16'h0100; r0_byteenable = 2'b11; r0_write = 1'b1;
    r1_address = 25'h200; r1_writedata = 16'h0200; r1_byteenable = 2'b11; r1_write = 1'b1;
    n0 = 0; n1 = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("t2_m_write", m_write, 1);
      check("t2_grant", m_address, (i % 2 == 0) ? 32'h100 : 32'h200);
      check("t2_wdata", m_writedata, (i % 2 == 0) ? 32'h0100 : 32'h0200);
      if (m_address == 25'h100) n0++;
      else if (m_address == 25'h200) n1++;
    end
    r0_write = 1'b0; r1_write = 1'b0;
    check("t2_r0_count", n0, 3);
    check("t2_r1_count", n1, 3);
    tick();
    check("t2_m_write_end", m_write, 0);

    // 3: controller stall holds the command register stable
    m_waitrequest = 1'b1;
    r0_address = 25'h33; r0_writedata = 16'h1234; r0_byteenable = 2'b01; r0_write = 1'b1;
    settle();
    check("t3_accept", r0_waitrequest, 0);
    tick();
    r0_writedata = 16'hBEEF; r0_byteenable = 2'b11;
    r1_address = 25'h44; r1_writedata = 16'h4444; r1_byteenable = 2'b11; r1_write = 1'b1;
    for (int i = 0; i < 4; i++) begin
      settle();
      check("t3_m_write", m_write, 1);
      check("t3_m_addr",  m_address, 32'h33);
      check("t3_m_wdata", m_writedata, 32'h1234);
      check("t3_m_be",    m_byteenable, 32'h1);
      check("t3_r0_wait", r0_waitrequest, 1);
      check("t3_r1_wait", r1_waitrequest, 1);
      if (i < 3) tick();
    end
    r0_write = 1'b0; r1_write = 1'b0; m_waitrequest = 1'b0;
    tick();
    check("t3_m_write_end", m_write, 0);

    // 4: r1 fills the tag FIFO; writes still pass; one return reopens reads
    r1_address = 25'h40; r1_read = 1'b1;
    for (int i = 0; i < 8; i++) begin
      settle();
      check("t4_r1_accept", r1_waitrequest, 0);
      tick();
    end
    settle();
    check("t4_r1_stall_a", r1_waitrequest, 1);
    check("t4_count_7",    dut.w_fifo_count, 7);
    tick();
    check("t4_r1_stall_b", r1_waitrequest, 1);
    check("t4_count_8",    dut.w_fifo_count, 8);
    r0_address = 25'h55; r0_writedata = 16'h5A5A; r0_byteenable = 2'b11; r0_write = 1'b1;
    settle();
    check("t4_r0_wr_accept", r0_waitrequest, 0);
    tick();
    check("t4_m_write", m_write, 1);
    check("t4_m_addr",  m_address, 32'h55);
    r0_write = 1'b0;
    m_readdata = 16'h0F0F; m_readdatavalid = 1'b1;
    settle();
    check("t4_r1_stall_c", r1_waitrequest, 1);
    tick();
    settle();
    check("t4_r1_rdv",     r1_readdatavalid, 1);
    check("t4_r1_data",    r1_readdata, 32'h0F0F);
    check("t4_count_pop",  dut.w_fifo_count, 7);
    check("t4_r1_reopen",  r1_waitrequest, 0);
    r1_read = 1'b0;
    repeat (7) tick();
    m_readdatavalid = 1'b0;
    tick();
    check("t4_drained", dut.w_fifo_count, 0);
    check("t4_no_err",  err_orphan, 0);

    // 5: orphan return
    m_readdata = 16'h7777; m_readdatavalid = 1'b1;
    tick();
    m_readdatavalid = 1'b0;
    settle();
    check("t5_r0_rdv", r0_readdatavalid, 0);
    check("t5_r1_rdv", r1_readdatavalid, 0);
    check("t5_err",    err_orphan, 1);
    repeat (3) tick();
    check("t5_err_sticky", err_orphan, 1);

    // 6: asynchronous reset with three reads pending and a fourth on the bus
    r0_address = 25'h60; r0_read = 1'b1;
    repeat (4) tick();
    check("t6_pre_count", dut.w_fifo_count, 3);
    check("t6_pre_read",  m_read, 1);
    reset_reset_n = 1'b0;
    idle_inputs();
    settle();
    check("t6_m_read",   m_read, 0);
    check("t6_m_addr",   m_address, 0);
    check("t6_count",    dut.w_fifo_count, 0);
    check("t6_err",      err_orphan, 0);
    check("t6_r0_data",  r0_readdata, 0);
    check("t6_r1_data",  r1_readdata, 0);
    check("t6_r0_wait",  r0_waitrequest, 1);
    check("t6_r1_wait",  r1_waitrequest, 1);
    check("t6_r0_rdv",   r0_readdatavalid, 0);
    tick();
    reset_reset_n = 1'b1;
    m_readdata = 16'h1111; m_readdatavalid = 1'b1;
    tick();
    m_readdatavalid = 1'b0;
    settle();
    check("t6_late_orphan", err_orphan, 1);
    check("t6_late_no_rdv", r0_readdatavalid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
